// File: rtl/present_pkg.sv
// present_pkg: shared present type codes, effect states and default effect constants
package present_pkg;

    typedef enum logic [1:0] {
        PRES_LIFE   = 2'd0,
        PRES_FREEZE = 2'd1,
        PRES_SHIELD = 2'd2,
        PRES_BONUS  = 2'd3
    } present_t;

    typedef enum logic {
        EFF_IDLE,
        EFF_ACTIVE
    } effect_st_t;

    localparam int FREEZE_TIME_DEF  = 5;
    localparam int SHIELD_TIME_DEF  = 8;
    localparam int BONUS_POINTS_DEF = 50;
    localparam int TIMER_W_DEF      = 4;

endpackage

// File: rtl/effect_timer.sv
// effect_timer: IDLE/ACTIVE effect FSM with a per-second countdown, reload and early consume
module effect_timer
    import present_pkg::*;
#(
    parameter int DURATION = 5,
    parameter int TIMER_W  = 4
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               clear,
    input  logic               load,
    input  logic               secClk,
    input  logic               consume,
    output logic               active,
    output logic [TIMER_W-1:0] remaining
);

    effect_st_t state;

    assign active = (state == EFF_ACTIVE);

    // priority: reset/clear, reload, consume, then the once-per-second countdown
    always_ff @(posedge clk) begin
        if (!resetN || clear) begin
            state     <= EFF_IDLE;
            remaining <= '0;
        end else if (load) begin
            state     <= EFF_ACTIVE;
            remaining <= TIMER_W'(DURATION);
        end else if (state == EFF_ACTIVE && consume) begin
            state     <= EFF_IDLE;
            remaining <= '0;
        end else if (state == EFF_ACTIVE && secClk) begin
            state     <= (remaining == TIMER_W'(1)) ? EFF_IDLE : EFF_ACTIVE;
            remaining <= remaining - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/present_effects.sv
// present_effects: applies collected presents (life, freeze, shield, bonus) and filters player hits
module present_effects
    import present_pkg::*;
#(
    parameter int FREEZE_TIME  = FREEZE_TIME_DEF,
    parameter int SHIELD_TIME  = SHIELD_TIME_DEF,
    parameter int BONUS_POINTS = BONUS_POINTS_DEF,
    parameter int TIMER_W      = TIMER_W_DEF
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               col_present,
    input  logic [1:0]         present_type,
    input  logic               secClk,
    input  logic               level_reset,
    input  logic               player_hit,
    output logic               add_life,
    output logic [7:0]         score_add,
    output logic               freeze_active,
    output logic               shield_active,
    output logic [TIMER_W-1:0] freeze_left,
    output logic [TIMER_W-1:0] shield_left,
    output logic               player_hit_out
);

    logic col_present_d;
    logic collect;

    assign collect = col_present & ~col_present_d;

    // edge detector and one-cycle pulse outputs; level_reset also rearms the edge detector
    always_ff @(posedge clk) begin
        if (!resetN || level_reset) begin
            col_present_d  <= 1'b0;
            add_life       <= 1'b0;
            score_add      <= '0;
            player_hit_out <= 1'b0;
        end else begin
            col_present_d  <= col_present;
            add_life       <= collect && present_type == PRES_LIFE;
            score_add      <= (collect && present_type == PRES_BONUS) ? 8'(BONUS_POINTS) : 8'd0;
            player_hit_out <= player_hit & ~shield_active;
        end
    end

    effect_timer #(.DURATION(FREEZE_TIME), .TIMER_W(TIMER_W)) u_freeze (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (level_reset),
        .load     (collect && present_type == PRES_FREEZE),
        .secClk   (secClk),
        .consume  (1'b0),
        .active   (freeze_active),
        .remaining(freeze_left)
    );

    effect_timer #(.DURATION(SHIELD_TIME), .TIMER_W(TIMER_W)) u_shield (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (level_reset),
        .load     (collect && present_type == PRES_SHIELD),
        .secClk   (secClk),
        .consume  (player_hit & shield_active),
        .active   (shield_active),
        .remaining(shield_left)
    );

endmodule

// File: tb/tb_present_effects.sv
// tb_present_effects: directed vectors with a queue scoreboard checked by an independent monitor
module tb_present_effects;

    logic       clk, resetN, col_present, secClk, level_reset, player_hit;
    logic [1:0] present_type;
    logic       add_life, freeze_active, shield_active, player_hit_out;
    logic [7:0] score_add;
    logic [3:0] freeze_left, shield_left;

    typedef struct packed {
        logic       al;
        logic [7:0] sa;
        logic       fa;
        logic [3:0] fl;
        logic       sha;
        logic [3:0] sl;
        logic       ho;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;

    present_effects dut (
        .clk           (clk),
        .resetN        (resetN),
        .col_present   (col_present),
        .present_type  (present_type),
        .secClk        (secClk),
        .level_reset   (level_reset),
        .player_hit    (player_hit),
        .add_life      (add_life),
        .score_add     (score_add),
        .freeze_active (freeze_active),
        .shield_active (shield_active),
        .freeze_left   (freeze_left),
        .shield_left   (shield_left),
        .player_hit_out(player_hit_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // monitor: every posedge the registered outputs are due for the oldest queued expectation
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            exp_t  g;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            g = '{add_life, score_add, freeze_active, freeze_left, shield_active, shield_left, player_hit_out};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL %s: got al=%0d sa=%0d fa=%0d fl=%0d sha=%0d sl=%0d ho=%0d expected al=%0d sa=%0d fa=%0d fl=%0d sha=%0d sl=%0d ho=%0d",
                         n, g.al, g.sa, g.fa, g.fl, g.sha, g.sl, g.ho, e.al, e.sa, e.fa, e.fl, e.sha, e.sl, e.ho);
            end
        end
    end

    // drive one cycle of inputs and queue the outputs expected after the next edge
    task automatic step(input logic rn, input logic c, input logic [1:0] t, input logic s,
                        input logic lr, input logic h, input logic al, input logic [7:0] sa,
                        input logic fa, input logic [3:0] fl, input logic sha, input logic [3:0] sl,
                        input logic ho, input string n);
        resetN       = rn;
        col_present  = c;
        present_type = t;
        secClk       = s;
        level_reset  = lr;
        player_hit   = h;
        exp_q.push_back('{al, sa, fa, fl, sha, sl, ho});
        name_q.push_back(n);
        @(negedge clk);
    endtask

    initial begin
        resetN = 1'b0; col_present = 1'b0; present_type = 2'd0;
        secClk = 1'b0; level_reset = 1'b0; player_hit = 1'b0;
        @(negedge clk);
        //   rn c  t  s  lr h   al sa  fa fl sha sl ho
        step(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "reset0");
        step(0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "reset1");
        step(1, 1, 0, 0, 0, 0,  1, 0,  0, 0, 0, 0, 0, "life_pulse");
        step(1, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "life_held1");
        step(1, 1, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "life_held2");
        step(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "life_release");
        step(1, 1, 1, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "freeze_load");
        for (int i = 4; i >= 1; i--)
            step(1, 0, 0, 1, 0, 0,  0, 0,  1, 4'(i), 0, 0, 0, "freeze_count");
        step(1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 0, 0, 0, "freeze_expire");
        step(1, 1, 1, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "freeze_load2");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 4, 0, 0, 0, "freeze_4");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 3, 0, 0, 0, "freeze_3");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 2, 0, 0, 0, "freeze_2");
        step(1, 1, 1, 1, 0, 0,  0, 0,  1, 5, 0, 0, 0, "reload_beats_sec");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "reload_hold");
        step(1, 1, 2, 0, 0, 0,  0, 0,  1, 5, 1, 8, 0, "shield_load");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 4, 1, 7, 0, "shield_7");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 3, 1, 6, 0, "shield_6");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 2, 1, 5, 0, "shield_5");
        step(1, 0, 0, 0, 0, 1,  0, 0,  1, 2, 0, 0, 0, "hit_absorbed");
        step(1, 0, 0, 0, 0, 1,  0, 0,  1, 2, 0, 0, 1, "hit_passes");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 2, 0, 0, 0, "hit_one_cycle");
        step(1, 1, 3, 0, 0, 0,  0, 50, 1, 2, 0, 0, 0, "bonus_pulse");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 2, 0, 0, 0, "bonus_clear");
        step(1, 0, 0, 0, 0, 1,  0, 0,  1, 2, 0, 0, 1, "hit_no_shield");
        step(1, 1, 2, 0, 0, 1,  0, 0,  1, 2, 1, 8, 1, "hit_with_collect");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 2, 1, 8, 0, "shield_armed");
        step(1, 0, 0, 1, 0, 0,  0, 0,  1, 1, 1, 7, 0, "both_count");
        step(1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 1, 6, 0, "freeze_out");
        for (int i = 5; i >= 1; i--)
            step(1, 0, 0, 1, 0, 0,  0, 0,  0, 0, 1, 4'(i), 0, "shield_count");
        step(1, 0, 0, 1, 0, 1,  0, 0,  0, 0, 0, 0, 0, "hit_at_expiry");
        step(1, 1, 1, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "lr_freeze");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "lr_gap");
        step(1, 1, 2, 0, 0, 0,  0, 0,  1, 5, 1, 8, 0, "lr_shield");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 5, 1, 8, 0, "lr_both");
        step(1, 1, 1, 1, 1, 1,  0, 0,  0, 0, 0, 0, 0, "level_reset");
        step(1, 1, 1, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "fresh_collect");
        step(1, 0, 0, 0, 0, 0,  0, 0,  1, 5, 0, 0, 0, "after_fresh");
        step(1, 1, 3, 0, 0, 0,  0, 50, 1, 5, 0, 0, 0, "bonus_again");
        step(0, 1, 0, 1, 0, 1,  0, 0,  0, 0, 0, 0, 0, "reset_mid");
        step(1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, "post_reset");
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
